// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port round-robin memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 2;

endpackage

// File: rtl/mem_port_arbiter_mem_array.sv
// Single-port DEPTH x DATA_W register array with registered read port.
module mem_array #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port scratch memory between two
// requesters; every access is a grant cycle followed by one ACCESS cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy
);

  state_t            state, state_next;
  logic              last_grant;
  logic              port_q, rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              grant, winner, win_rw;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  // The memory read is launched on the grant edge so read data can land in
  // rdata0/rdata1 exactly on the ACCESS edge.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    winner     = PORT0;
    if (req0 && req1) winner = (last_grant == PORT0) ? PORT1 : PORT0;
    else if (req1)    winner = PORT1;

    win_rw    = (winner == PORT1) ? rw1    : rw0;
    win_addr  = (winner == PORT1) ? addr1  : addr0;
    win_wdata = (winner == PORT1) ? wdata1 : wdata0;

    case (state)
      IDLE: begin
        if (en && (req0 || req1)) begin
          grant      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    mem_we   = (state == ACCESS) && rw_q;
    mem_re   = grant && !win_rw;
    mem_addr = (state == ACCESS) ? addr_q : win_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT1;
      port_q     <= PORT0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      gnt0  <= grant && (winner == PORT0);
      gnt1  <= grant && (winner == PORT1);
      done0 <= (state == ACCESS) && (port_q == PORT0);
      done1 <= (state == ACCESS) && (port_q == PORT1);
      busy  <= (state_next == ACCESS);
      if (grant) begin
        last_grant <= winner;
        port_q     <= winner;
        rw_q       <= win_rw;
        addr_q     <= win_addr;
        wdata_q    <= win_wdata;
      end
      if ((state == ACCESS) && !rw_q) begin
        if (port_q == PORT0) rdata0 <= mem_rdata;
        else                 rdata1 <= mem_rdata;
      end
    end
  end

  mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected read data is queued at issue
// and popped when the matching done pulse appears.
module tb_mem_port_arbiter;

  logic       clk, rst, en;
  logic       req0, rw0, gnt0, done0;
  logic [1:0] addr0;
  logic [3:0] wdata0, rdata0;
  logic       req1, rw1, gnt1, done1;
  logic [1:0] addr1;
  logic [3:0] wdata1, rdata1;
  logic       busy;

  int         total, bad;
  logic [3:0] ref_mem [4];
  logic       last_grant_m;
  logic [4:0] sb [$];

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .en(en),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request at a negedge and observes it until its done cycle.
  task automatic issue(input bit port, input bit rw, input logic [1:0] addr,
                       input logic [3:0] wd, input bit scramble,
                       output int gwait, output bit done_ok, output bit busy_g,
                       output bit busy_d, output logic [3:0] rd);
    gwait = -1; done_ok = 0; busy_g = 0; busy_d = 1; rd = 'x;
    if (port) begin req1 = 1; rw1 = rw; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1; rw0 = rw; addr0 = addr; wdata0 = wd; end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((port ? gnt1 : gnt0) === 1'b1) begin gwait = i; break; end
    end
    busy_g = busy;
    if (port) req1 = 0; else req0 = 0;
    if (scramble) begin
      if (port) begin addr1 = ~addr; wdata1 = ~wd; end
      else      begin addr0 = ~addr; wdata0 = ~wd; end
    end
    if (gwait < 0) return;
    last_grant_m = port;
    @(negedge clk);
    done_ok = port ? done1 : done0;
    busy_d  = busy;
    rd      = port ? rdata1 : rdata0;
    if (done_ok && rw) ref_mem[addr] = wd;
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk); @(negedge clk);
    total++; if ({gnt0, gnt1, done0, done1, busy} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_ctrl got=%b want=00000", {gnt0, gnt1, done0, done1, busy}); end
    total++; if (rdata0 !== 4'h0) begin bad++; $display("[TB] FAIL reset_rdata0 got=%h want=0", rdata0); end
    total++; if (rdata1 !== 4'h0) begin bad++; $display("[TB] FAIL reset_rdata1 got=%h want=0", rdata1); end
    rst = 0;
    for (int i = 0; i < 4; i++) ref_mem[i] = 4'h0;
    last_grant_m = 1'b1;
  endtask

  task automatic test_read_after_reset();
    int gw; bit dn, bg, bd; logic [3:0] rd; logic [4:0] e;
    sb.push_back({1'b0, ref_mem[2]});
    issue(1'b0, 1'b0, 2'd2, 4'h0, 1'b0, gw, dn, bg, bd, rd);
    total++; if (gw !== 1) begin bad++; $display("[TB] FAIL rd_gnt_latency got=%0d want=1", gw); end
    total++; if (dn !== 1'b1) begin bad++; $display("[TB] FAIL rd_done0 got=%b want=1", dn); end
    total++; if ({bg, bd} !== 2'b10) begin bad++; $display("[TB] FAIL rd_busy got=%b want=10", {bg, bd}); end
    e = (sb.size() > 0) ? sb.pop_front() : 5'h1f;
    total++; if (rd !== e[3:0]) begin bad++; $display("[TB] FAIL rd_data0 got=%h want=%h", rd, e[3:0]); end
  endtask

  task automatic test_write_then_read();
    int gw; bit dn, bg, bd; logic [3:0] rd; logic [4:0] e;
    issue(1'b0, 1'b1, 2'd1, 4'hA, 1'b0, gw, dn, bg, bd, rd);
    total++; if (dn !== 1'b1) begin bad++; $display("[TB] FAIL wr_done0 got=%b want=1", dn); end
    sb.push_back({1'b1, ref_mem[1]});
    issue(1'b1, 1'b0, 2'd1, 4'h0, 1'b0, gw, dn, bg, bd, rd);
    total++; if (gw !== 1 || dn !== 1'b1) begin bad++; $display("[TB] FAIL rd1_handshake got=%0d/%b want=1/1", gw, dn); end
    e = (sb.size() > 0) ? sb.pop_front() : 5'h1f;
    total++; if (rd !== e[3:0]) begin bad++; $display("[TB] FAIL rd1_data got=%h want=%h", rd, e[3:0]); end
    total++; if (rdata0 !== 4'h0) begin bad++; $display("[TB] FAIL rdata0_hold got=%h want=0", rdata0); end
  endtask

  task automatic test_back_to_back();
    int grants = 0, last_c = -1, c = 0;
    bit both = 0, p;
    logic exp_p;
    logic [4:0] e;
    exp_p = ~last_grant_m;
    req0 = 1; rw0 = 0; addr0 = 2'd0;
    req1 = 1; rw1 = 0; addr1 = 2'd1;
    while (c < 40 && (grants < 4 || sb.size() > 0)) begin
      @(negedge clk); c++;
      if (gnt0 && gnt1) both = 1;
      if (done0 || done1) begin
        e = (sb.size() > 0) ? sb.pop_front() : 5'h1f;
        p = done1;
        total++; if ({p, p ? rdata1 : rdata0} !== e) begin
          bad++; $display("[TB] FAIL b2b_read got=%h want=%h", {p, p ? rdata1 : rdata0}, e); end
      end
      if (gnt0 || gnt1) begin
        p = gnt1;
        total++; if (p !== exp_p) begin bad++; $display("[TB] FAIL b2b_order got=%b want=%b", p, exp_p); end
        if (last_c >= 0) begin
          total++; if (c - last_c != 2) begin bad++; $display("[TB] FAIL b2b_spacing got=%0d want=2", c - last_c); end
        end
        last_c = c;
        sb.push_back({p, ref_mem[p ? 2'd1 : 2'd0]});
        last_grant_m = p;
        exp_p = ~p;
        grants++;
        if (grants == 4) begin req0 = 0; req1 = 0; end
      end
    end
    req0 = 0; req1 = 0;
    total++; if (grants != 4) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=4", grants); end
    total++; if (both) begin bad++; $display("[TB] FAIL b2b_exclusive got=1 want=0"); end
    @(negedge clk);
  endtask

  task automatic test_enable();
    logic [4:0] e;
    en = 0; req1 = 1; rw1 = 0; addr1 = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if ({gnt1, busy} !== 2'b00) begin bad++; $display("[TB] FAIL en_block got=%b want=00", {gnt1, busy}); end
    end
    en = 1;
    sb.push_back({1'b1, ref_mem[1]});
    @(negedge clk);
    total++; if (gnt1 !== 1'b1) begin bad++; $display("[TB] FAIL en_gnt1 got=%b want=1", gnt1); end
    req1 = 0; last_grant_m = 1'b1;
    @(negedge clk);
    e = (sb.size() > 0) ? sb.pop_front() : 5'h1f;
    total++; if ({done1, rdata1} !== {1'b1, e[3:0]}) begin
      bad++; $display("[TB] FAIL en_done1 got=%h want=%h", {done1, rdata1}, {1'b1, e[3:0]}); end
  endtask

  task automatic test_reset_mid_access();
    req1 = 1; rw1 = 1; addr1 = 2'd3; wdata1 = 4'h5;
    @(negedge clk);
    total++; if (gnt1 !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_gnt1 got=%b want=1", gnt1); end
    req1 = 0;
    rst = 1; #1;
    total++; if ({gnt0, gnt1, done0, done1, busy, rdata0, rdata1} !== 13'b0) begin
      bad++; $display("[TB] FAIL rst_mid_outputs got=%h want=0", {gnt0, gnt1, done0, done1, busy, rdata0, rdata1}); end
    @(negedge clk);
    total++; if (done1 !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_done1 got=%b want=0", done1); end
    rst = 0;
    for (int i = 0; i < 4; i++) ref_mem[i] = 4'h0;
    last_grant_m = 1'b1;
    sb.delete();
    req0 = 1; rw0 = 0; addr0 = 2'd3;
    req1 = 1; rw1 = 0; addr1 = 2'd3;
    @(negedge clk);
    total++; if ({gnt0, gnt1} !== (last_grant_m ? 2'b10 : 2'b01)) begin
      bad++; $display("[TB] FAIL rst_tie got=%b want=10", {gnt0, gnt1}); end
    req0 = 0;
    @(negedge clk);
    total++; if ({done0, rdata0} !== {1'b1, ref_mem[3]}) begin
      bad++; $display("[TB] FAIL rst_read3 got=%h want=%h", {done0, rdata0}, {1'b1, ref_mem[3]}); end
    @(negedge clk);
    total++; if (gnt1 !== 1'b1) begin bad++; $display("[TB] FAIL rst_loser_gnt1 got=%b want=1", gnt1); end
    req1 = 0; last_grant_m = 1'b1;
    @(negedge clk);
    total++; if ({done1, rdata1} !== {1'b1, ref_mem[3]}) begin
      bad++; $display("[TB] FAIL rst_read3_p1 got=%h want=%h", {done1, rdata1}, {1'b1, ref_mem[3]}); end
  endtask

  task automatic test_isolation();
    int gw; bit dn, bg, bd; logic [3:0] rd; logic [4:0] e;
    issue(1'b0, 1'b1, 2'd2, 4'h7, 1'b1, gw, dn, bg, bd, rd);
    total++; if (dn !== 1'b1) begin bad++; $display("[TB] FAIL iso_wr_done got=%b want=1", dn); end
    for (int a = 1; a <= 2; a++) begin
      sb.push_back({1'b1, ref_mem[a]});
      issue(1'b1, 1'b0, a[1:0], 4'h0, 1'b0, gw, dn, bg, bd, rd);
      e = (sb.size() > 0) ? sb.pop_front() : 5'h1f;
      total++; if (rd !== e[3:0]) begin
        bad++; $display("[TB] FAIL iso_read_addr%0d got=%h want=%h", a, rd, e[3:0]); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1; en = 1;
    req0 = 0; rw0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; rw1 = 0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_read_after_reset();
    test_write_then_read();
    test_back_to_back();
    test_enable();
    test_reset_mid_access();
    test_isolation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
